ula_control_fsm: RTL and testbench
==================================

Name: ula_control_fsm

Overview:
- Multi-cycle control unit for the 16-bit processor datapath.
- Fetches a 16-bit instruction word from memory and decodes it.
- Sequences the register file, the A register, the ULA (op select, shift select, G register) and the memory address/data registers over T0..T5 time steps.
- Keeps a latched zero flag from the ULA for conditional moves.

Parameters:
- PC_REG, 7, register index used as program counter; always driven by R_out[PC_REG] during fetch.
- NREG, 8, number of general registers; width of the R_in/R_out one-hot vectors.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  level; starts/continues instruction execution.
- DIN  input  16  memory read data; latched into IR in T2.
- z_flag  input  1  ULA combinational zero flag.
- IR  output  16  current instruction register.
- R_in  output  NREG  one-hot register write enables.
- R_out  output  NREG  one-hot register bus drivers.
- A_in  output  1  load A register from bus.
- G_in  output  1  load G register from ULA output.
- G_out  output  1  G drives bus.
- DIN_out  output  1  DIN drives bus.
- ALU  output  2  ULA op: 00 add, 01 sub, 10 and.
- shift_in  output  1  ULA selects shift path.
- ADDR_in  output  1  load memory address register.
- DOUT_in  output  1  load memory write-data register.
- W_D  output  1  memory write enable.
- incr_pc  output  1  increment PC register.
- Z  output  1  latched zero flag.
- Done  output  1  one-cycle pulse in last step of instruction.

Behaviour:
- Encoding: IR[15:13] opcode, IR[12:10] rX, IR[9:7] rY, IR[6] shift select (opcode 111 only). Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 and (IR[6]=0) / shift (IR[6]=1).
- States: IDLE, T0, T1, T2, T3, T4, T5.
  - IDLE -> T0 when Run=1.
  - T0 -> T1 -> T2 -> T3 unconditionally.
  - The step asserting Done goes to T0 if Run=1, else IDLE.
  - Run deasserted mid-instruction does not abort; the instruction completes.
- Outputs are combinational decode of state and IR; any output not listed for a step is 0. In IDLE all outputs are 0.
- Fetch:
  - T0: R_out[PC_REG], ADDR_in, incr_pc.
  - T1: memory wait, no outputs.
  - T2: IR <= DIN at the edge ending T2.
- Execute:
  - mv: T3 R_out[Y], R_in[X], Done.
  - mvi: T3 R_out[PC_REG], ADDR_in, incr_pc; T4 wait; T5 DIN_out, R_in[X], Done.
  - add/sub/and/shift: T3 R_out[X], A_in; T4 R_out[Y], G_in, ALU=00/01/10 (10 for shift, which is don't-care), shift_in=1 only for shift; T5 G_out, R_in[X], Done.
  - ld: T3 R_out[Y], ADDR_in; T4 wait; T5 DIN_out, R_in[X], Done.
  - st: T3 R_out[Y], ADDR_in; T4 R_out[X], DOUT_in, W_D, Done.
  - mvnz: T3 Done always; R_out[Y] and R_in[X] only if Z=0.
- Z register: Z <= z_flag at the clock edge ending any cycle with G_in=1. Otherwise Z holds; only arithmetic/logic/shift instructions update it.
- Bus rule: at most one of {any R_out bit, G_out, DIN_out} is 1 in any cycle. R_in and R_out are each zero- or one-hot.
- X == Y is legal; R_out and R_in use the same index.
- Reset (any state, including mid-instruction): state=IDLE, IR=0, Z=0, all outputs 0 on the next cycle. Reset has priority over Run.
- Done is high for exactly one cycle per instruction.
- Latencies:
  - mv and mvnz: 4 cycles T0..T3.
  - st: 5 cycles.
  - mvi, ld, add, sub, and, shift: 6 cycles.

Test Plan:
- Reset held 2 cycles with Run=1, then released -> all outputs 0 and IR=0 during reset. T0 is entered on the cycle after release; R_out=8'h80, ADDR_in=1, incr_pc=1.
- DIN=16'h4A80 (add r2,r5) -> T2 IR=16'h4A80.
  - T3: R_out=8'h04, A_in=1.
  - T4: R_out=8'h20, G_in=1, ALU=00.
  - T5: G_out=1, R_in=8'h04, Done=1.
- sub with z_flag=1 during T4, then DIN=16'hC480 (mvnz r1,r1) -> Z=1 after sub, and mvnz T3 has R_in=0, R_out=0, Done=1.
- DIN=16'hA080 (st r0,r1) -> T3 R_out=8'h02, ADDR_in=1; T4 R_out=8'h01, DOUT_in=1, W_D=1, Done=1. Next state is T0 with Run=1, IDLE with Run=0.
- DIN=16'hE040 (shift r0) -> T4 shift_in=1, G_in=1; T5 G_out=1, R_in=8'h01.
- Reset asserted in T4 of ld -> IDLE next cycle, no Done, no R_in pulse. With Run=1 after release, the first fetch restarts at T0.

Source files
------------

// File: rtl/ula_control_fsm.sv
// Multi-cycle control unit for the 16-bit ULA datapath. It fetches and decodes an instruction,
// then sequences the register file, A/G registers, ULA and memory interface over T0..T5.
module ula_control_fsm #(
  parameter int PC_REG = 7,
  parameter int NREG   = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [15:0]     DIN,
  input  logic            z_flag,
  output logic [15:0]     IR,
  output logic [NREG-1:0] R_in,
  output logic [NREG-1:0] R_out,
  output logic            A_in,
  output logic            G_in,
  output logic            G_out,
  output logic            DIN_out,
  output logic [1:0]      ALU,
  output logic            shift_in,
  output logic            ADDR_in,
  output logic            DOUT_in,
  output logic            W_D,
  output logic            incr_pc,
  output logic            Z,
  output logic            Done
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  state_t     state;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       shift_sel;

  assign opcode    = IR[15:13];
  assign rx        = IR[12:10];
  assign ry        = IR[9:7];
  assign shift_sel = IR[6];

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // State, instruction register and latched zero flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      IR    <= '0;
      Z     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Run) state <= T0;
        T0:   state <= T1;
        T1:   state <= T2;
        T2: begin
          state <= T3;
          IR    <= DIN;
        end
        T3, T4, T5: begin
          if (Done)             state <= Run ? T0 : IDLE;
          else if (state == T3) state <= T4;
          else if (state == T4) state <= T5;
          else                  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Only ALU-type steps load G, so only they refresh the zero flag
      if (G_in) Z <= z_flag;
    end
  end

  // Control decode from current step and instruction
  always_comb begin
    R_in     = '0;
    R_out    = '0;
    A_in     = 1'b0;
    G_in     = 1'b0;
    G_out    = 1'b0;
    DIN_out  = 1'b0;
    ALU      = ALU_ADD;
    shift_in = 1'b0;
    ADDR_in  = 1'b0;
    DOUT_in  = 1'b0;
    W_D      = 1'b0;
    incr_pc  = 1'b0;
    Done     = 1'b0;
    case (state)
      T0: begin
        R_out[PC_REG] = 1'b1;
        ADDR_in       = 1'b1;
        incr_pc       = 1'b1;
      end
      T3: begin
        case (opcode)
          OP_MV: begin
            R_out = onehot(ry);
            R_in  = onehot(rx);
            Done  = 1'b1;
          end
          OP_MVI: begin
            R_out[PC_REG] = 1'b1;
            ADDR_in       = 1'b1;
            incr_pc       = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            R_out = onehot(rx);
            A_in  = 1'b1;
          end
          OP_LD, OP_ST: begin
            R_out   = onehot(ry);
            ADDR_in = 1'b1;
          end
          OP_MVNZ: begin
            if (!Z) begin
              R_out = onehot(ry);
              R_in  = onehot(rx);
            end
            Done = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (opcode)
          OP_ADD: begin
            R_out = onehot(ry);
            G_in  = 1'b1;
            ALU   = ALU_ADD;
          end
          OP_SUB: begin
            R_out = onehot(ry);
            G_in  = 1'b1;
            ALU   = ALU_SUB;
          end
          OP_AND: begin
            R_out    = onehot(ry);
            G_in     = 1'b1;
            ALU      = ALU_AND;
            shift_in = shift_sel;
          end
          OP_ST: begin
            R_out   = onehot(rx);
            DOUT_in = 1'b1;
            W_D     = 1'b1;
            Done    = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (opcode)
          OP_MVI, OP_LD: begin
            DIN_out = 1'b1;
            R_in    = onehot(rx);
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            G_out = 1'b1;
            R_in  = onehot(rx);
            Done  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ula_control_fsm.sv
// Directed bench for ula_control_fsm: walks instructions step by step and checks every
// control output, IR and Z against hand-computed values at the falling clock edge.
module tb_ula_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic        z_flag;
  logic [15:0] IR;
  logic [7:0]  R_in, R_out;
  logic        A_in, G_in, G_out, DIN_out, shift_in, ADDR_in, DOUT_in, W_D, incr_pc, Z, Done;
  logic [1:0]  ALU;

  int checks = 0;
  int errors = 0;

  ula_control_fsm #(.PC_REG(7), .NREG(8)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .z_flag(z_flag),
    .IR(IR), .R_in(R_in), .R_out(R_out), .A_in(A_in), .G_in(G_in), .G_out(G_out),
    .DIN_out(DIN_out), .ALU(ALU), .shift_in(shift_in), .ADDR_in(ADDR_in),
    .DOUT_in(DOUT_in), .W_D(W_D), .incr_pc(incr_pc), .Z(Z), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic cyc();
    @(negedge Clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed order: R_out R_in A_in G_in G_out DIN_out ALU shift_in ADDR_in DOUT_in W_D incr_pc Done
  task automatic outs(input string tag, input logic [7:0] ro, input logic [7:0] ri,
                      input logic a, input logic g, input logic go, input logic dio,
                      input logic [1:0] alu, input logic sh, input logic ad,
                      input logic dout, input logic wd, input logic ip, input logic dn);
    chk(tag, {4'h0, R_out, R_in, A_in, G_in, G_out, DIN_out, ALU, shift_in, ADDR_in,
              DOUT_in, W_D, incr_pc, Done},
             {4'h0, ro, ri, a, g, go, dio, alu, sh, ad, dout, wd, ip, dn});
  endtask

  task automatic zeros(input string tag);
    outs(tag, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch_t0(input string tag);
    outs(tag, 8'h80, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1, 0);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; DIN = 16'h0000; z_flag = 1'b0;

    cyc(); zeros("rst_c1"); chk("rst_ir", {16'h0, IR}, 32'h0); chk("rst_z", {31'h0, Z}, 32'h0);
    cyc(); zeros("rst_c2");
    Reset = 1'b0;

    // add r2,r5
    cyc(); fetch_t0("add_t0"); DIN = 16'h4A80;
    cyc(); zeros("add_t1");
    cyc(); zeros("add_t2"); chk("add_t2_ir", {16'h0, IR}, 32'h0);
    cyc(); chk("add_ir", {16'h0, IR}, 32'h4A80);
           outs("add_t3", 8'h04, 8'h00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(); outs("add_t4", 8'h20, 8'h00, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(); outs("add_t5", 8'h00, 8'h04, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1);

    // sub r1,r1 with zero result
    cyc(); fetch_t0("sub_t0"); DIN = 16'h6480;
    cyc(); cyc();
    cyc(); chk("sub_ir", {16'h0, IR}, 32'h6480);
           outs("sub_t3", 8'h02, 8'h00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(); outs("sub_t4", 8'h02, 8'h00, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0); z_flag = 1'b1;
    cyc(); chk("sub_z", {31'h0, Z}, 32'h1); z_flag = 1'b0;
           outs("sub_t5", 8'h00, 8'h02, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1);

    // mvnz r1,r1 with Z=1: no move
    cyc(); fetch_t0("mvnz1_t0"); DIN = 16'hC480;
    cyc(); cyc();
    cyc(); outs("mvnz1_t3", 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
           chk("mvnz1_z", {31'h0, Z}, 32'h1);

    // st r0,r1 continuing with Run=1
    cyc(); fetch_t0("st_t0"); DIN = 16'hA080;
    cyc(); cyc();
    cyc(); outs("st_t3", 8'h02, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    cyc(); outs("st_t4", 8'h01, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 1);

    // shift r0, then stop with Run=0
    cyc(); fetch_t0("st_next_t0"); DIN = 16'hE040;
    cyc(); cyc();
    cyc(); outs("shf_t3", 8'h01, 8'h00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(); outs("shf_t4", 8'h01, 8'h00, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0);
    cyc(); outs("shf_t5", 8'h00, 8'h01, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1);
           chk("shf_z", {31'h0, Z}, 32'h0); Run = 1'b0;
    cyc(); zeros("idle_1");
    cyc(); zeros("idle_2"); Run = 1'b1;

    // ld r3,r2 aborted by reset in T4
    cyc(); fetch_t0("ld_t0"); DIN = 16'h8D00;
    cyc(); cyc();
    cyc(); outs("ld_t3", 8'h04, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
    cyc(); zeros("ld_t4"); Reset = 1'b1;
    cyc(); zeros("ld_rst"); chk("ld_rst_ir", {16'h0, IR}, 32'h0); Reset = 1'b0;

    // mvi r4 after restart
    cyc(); fetch_t0("mvi_t0"); DIN = 16'h3000;
    cyc(); cyc();
    cyc(); outs("mvi_t3", 8'h80, 8'h00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1, 0);
    cyc(); zeros("mvi_t4");
    cyc(); outs("mvi_t5", 8'h00, 8'h10, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1);

    // mv r3,r5
    cyc(); fetch_t0("mv_t0"); DIN = 16'h0E80;
    cyc(); cyc();
    cyc(); outs("mv_t3", 8'h20, 8'h08, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

    // and r2,r3 with nonzero result
    cyc(); fetch_t0("and_t0"); DIN = 16'hE980;
    cyc(); cyc();
    cyc(); outs("and_t3", 8'h04, 8'h00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(); outs("and_t4", 8'h08, 8'h00, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
    cyc(); outs("and_t5", 8'h00, 8'h04, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1);
           chk("and_z", {31'h0, Z}, 32'h0);

    // mvnz r1,r1 with Z=0: move happens, then stop
    cyc(); fetch_t0("mvnz0_t0"); DIN = 16'hC480;
    cyc(); cyc();
    cyc(); outs("mvnz0_t3", 8'h02, 8'h02, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1); Run = 1'b0;
    cyc(); zeros("end_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
